// File: rtl/sin_meas_pkg.sv
// Shared types and constants for the sine measurement block.
package sin_meas_pkg;

  localparam int unsigned DW      = 8;
  localparam int unsigned CW      = 12;
  localparam int unsigned MID     = 128;
  localparam int unsigned HYST    = 8;
  localparam int unsigned CNT_MAX = (1 << CW) - 1;

  typedef enum logic {
    SEEK = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/sin_meas_if.sv
// Sample input and measurement result bundle for sin_meas.
interface sin_meas_if;
  import sin_meas_pkg::*;

  logic [DW-1:0] din;
  logic          din_vld;
  logic [CW-1:0] period_o;
  logic [DW-1:0] vmax_o;
  logic [DW-1:0] vmin_o;
  logic [DW-1:0] amp_o;
  logic [DW-1:0] dc_o;
  logic          meas_vld;
  logic          lock_o;
  logic          tmo_o;

  modport master (
    output din, din_vld,
    input  period_o, vmax_o, vmin_o, amp_o, dc_o, meas_vld, lock_o, tmo_o
  );

  modport slave (
    input  din, din_vld,
    output period_o, vmax_o, vmin_o, amp_o, dc_o, meas_vld, lock_o, tmo_o
  );

endinterface

// File: rtl/sin_meas_xdet.sv
// Rising mid-scale crossing detector with re-arm hysteresis.
module sin_meas_xdet
  import sin_meas_pkg::*;
#(
  parameter int unsigned MID_P  = MID,
  parameter int unsigned HYST_P = HYST
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] i_din,
  input  logic          i_vld,
  input  logic          i_clr,
  output logic          o_xing_c
);

  localparam logic [DW-1:0] ARM_TH = DW'(MID_P - HYST_P);
  localparam logic [DW-1:0] MID_TH = DW'(MID_P);

  logic r_armed;

  assign o_xing_c = i_vld && r_armed && (i_din >= MID_TH);

  // Clear (timeout) wins over re-arm; a crossing consumes the arm.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_armed <= 1'b0;
    end else if (i_vld) begin
      if (i_clr)                r_armed <= 1'b0;
      else if (i_din < ARM_TH)  r_armed <= 1'b1;
      else if (o_xing_c)        r_armed <= 1'b0;
    end
  end

endmodule

// File: rtl/sin_meas.sv
// Period / amplitude meter for the 8-bit sine test path.
// Optional mid-point output enabled by defining SIN_MEAS_DC_EN.
module sin_meas
  import sin_meas_pkg::*;
#(
  parameter int unsigned MID_P  = MID,
  parameter int unsigned HYST_P = HYST
) (
  input  logic        clk,
  input  logic        rst_n,
  sin_meas_if.slave   bus
);

  state_e        r_state;
  state_e        w_state_nxt;
  logic          w_xing;
  logic          w_start;
  logic          w_publish;
  logic          w_accum;
  logic          w_tmo;

  logic [CW-1:0] r_cnt;
  logic [DW-1:0] r_rmax;
  logic [DW-1:0] r_rmin;
  logic [CW-1:0] r_period;
  logic [DW-1:0] r_vmax;
  logic [DW-1:0] r_vmin;
  logic [DW-1:0] r_amp;
  logic          r_meas_vld;
  logic          r_lock;
  logic          r_tmo;

  sin_meas_xdet #(
    .MID_P  (MID_P),
    .HYST_P (HYST_P)
  ) u_xdet (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_din    (bus.din),
    .i_vld    (bus.din_vld),
    .i_clr    (w_tmo),
    .o_xing_c (w_xing)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= SEEK;
    else        r_state <= w_state_nxt;
  end

  // Crossing beats saturation, so a crossing at CNT_MAX publishes normally.
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_publish   = 1'b0;
    w_accum     = 1'b0;
    w_tmo       = 1'b0;
    case (r_state)
      SEEK: begin
        if (w_xing) begin
          w_start     = 1'b1;
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        if (w_xing) begin
          w_publish = 1'b1;
          w_start   = 1'b1;
        end else if (bus.din_vld) begin
          if (r_cnt == CW'(CNT_MAX)) begin
            w_tmo       = 1'b1;
            w_state_nxt = SEEK;
          end else begin
            w_accum = 1'b1;
          end
        end
      end
      default: w_state_nxt = SEEK;
    endcase
  end

  // Running period statistics; the crossing sample opens the new period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_rmax <= '0;
      r_rmin <= '1;
    end else if (w_start) begin
      r_cnt  <= CW'(1);
      r_rmax <= bus.din;
      r_rmin <= bus.din;
    end else if (w_accum) begin
      r_cnt <= r_cnt + CW'(1);
      if (bus.din > r_rmax) r_rmax <= bus.din;
      if (bus.din < r_rmin) r_rmin <= bus.din;
    end else if (w_tmo) begin
      r_cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_period   <= '0;
      r_vmax     <= '0;
      r_vmin     <= '0;
      r_amp      <= '0;
      r_meas_vld <= 1'b0;
      r_lock     <= 1'b0;
      r_tmo      <= 1'b0;
    end else begin
      r_meas_vld <= w_publish;
      r_tmo      <= w_tmo;
      if (w_publish) begin
        r_period <= r_cnt;
        r_vmax   <= r_rmax;
        r_vmin   <= r_rmin;
        r_amp    <= r_rmax - r_rmin;
        r_lock   <= 1'b1;
      end else if (w_tmo) begin
        r_lock   <= 1'b0;
      end
    end
  end

`ifdef SIN_MEAS_DC_EN
  logic [DW:0]   w_dc_sum;
  logic [DW-1:0] r_dc;

  assign w_dc_sum = {1'b0, r_rmax} + {1'b0, r_rmin};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         r_dc <= '0;
    else if (w_publish) r_dc <= w_dc_sum[DW:1];
  end

  assign bus.dc_o = r_dc;
`else
  assign bus.dc_o = '0;
`endif

  assign bus.period_o = r_period;
  assign bus.vmax_o   = r_vmax;
  assign bus.vmin_o   = r_vmin;
  assign bus.amp_o    = r_amp;
  assign bus.meas_vld = r_meas_vld;
  assign bus.lock_o   = r_lock;
  assign bus.tmo_o    = r_tmo;

endmodule

// File: doc/sin_meas.md
Name: sin_meas

Overview:
- Consumer end of the sine test-signal path. Takes the 8-bit unsigned sample stream, either straight from the sine generator or from the FIR output.
- Detects rising mid-scale crossings with hysteresis, measures period in samples, and reports per-period max, min and peak-to-peak amplitude.
- Used on-chip and in benches to check that the generator and filter produce the expected waveform.

Parameters:
- DW, 8: sample width, unsigned offset-binary.
- CW, 12: period counter width.
- MID, 128: crossing threshold (mid-scale).
- HYST, 8: re-arm hysteresis. Arm when sample < MID-HYST.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- din  in  DW  input sample.
- din_vld  in  1  sample strobe, one sample per high cycle.
- period_o  out  CW  samples between the last two rising crossings.
- vmax_o  out  DW  maximum sample in the last period.
- vmin_o  out  DW  minimum sample in the last period.
- amp_o  out  DW  vmax_o - vmin_o.
- dc_o  out  DW  mid-point estimate (optional feature).
- meas_vld  out  1  one-cycle pulse when the outputs above update.
- lock_o  out  1  high after the first complete period, until timeout or reset.
- tmo_o  out  1  one-cycle pulse on period-counter saturation.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All outputs 0. State SEEK, armed=0, cnt=0, running max=0, running min=all-ones.
  - Reset mid-period discards all partial data.
- Only cycles with din_vld=1 change internal state. With din_vld=0 everything holds, and gaps are not counted.
- Arm and crossing:
  - armed is set by any valid sample < MID-HYST.
  - Crossing = armed && din >= MID. Crossing clears armed in the same cycle.
- State SEEK: waits for the first crossing. On it: cnt<=1, rmax<=rmin<=din, go to RUN. No meas_vld.
- State RUN, valid sample without crossing:
  - cnt<=cnt+1.
  - rmax<=max(rmax,din), rmin<=min(rmin,din).
- State RUN, crossing:
  - Publish period_o<=cnt, vmax_o<=rmax, vmin_o<=rmin, amp_o<=rmax-rmin.
  - meas_vld<=1 for one cycle; lock_o<=1.
  - Restart with cnt<=1, rmax<=rmin<=din.
  - The crossing sample belongs to the new period, not the one being published.
- Latency: outputs and meas_vld are registered and appear on the clock edge that samples the crossing. They are visible the cycle after din_vld with the crossing sample.
- Timeout:
  - In RUN, if cnt = 2^CW-1 and a further valid non-crossing sample arrives: tmo_o pulses, lock_o<=0, go to SEEK, armed<=0.
  - Published outputs hold their last values.
- Simultaneous events: a crossing on the sample that would saturate takes priority as a normal crossing (period_o=2^CW-1).
- Arithmetic:
  - amp_o is unsigned DW, never negative because rmax >= rmin.
  - cnt never wraps.
- Values published back-to-back hold until the next meas_vld.

Optional Feature:
- SIN_MEAS_DC_EN defined: dc_o<=(rmax+rmin)>>1, computed at DW+1 bits and truncated. It updates with meas_vld and resets to 0.
- Not defined: dc_o tied to 0 and no adder is synthesized. The port list is unchanged.

Decomposition:
- Shared package sin_meas_pkg holds:
  - state enum (SEEK, RUN);
  - default DW/CW/MID/HYST constants;
  - the CNT_MAX localparam.
- One sub-module, sin_meas_xdet, is natural. It holds the armed flag and hysteresis compare, and outputs a one-cycle crossing flag qualified by din_vld. The FSM, counter, extrema and output registers stay in sin_meas.

Test Plan:
- Continuous 32-point table sine: 128,152,176,…,255 (idx 8),…,0 (idx 24),…,102, din_vld=1 every cycle -> first meas_vld after the second crossing (one full cycle after lock-in). Required values: period_o=32, vmax_o=255, vmin_o=0, amp_o=255, lock_o=1, and dc_o=127 with SIN_MEAS_DC_EN.
- Same sine with din_vld low every other cycle -> period_o=32 still; meas_vld spacing 64 clocks.
- Constant din=100 after lock -> exactly 4095 samples later tmo_o pulses once, lock_o=0, period_o holds 32.
- Noisy crossing sequence 118,130,126,131 -> one crossing only, at 130. No second crossing without a sample < 120.
- rst_n low for 1 cycle mid-period -> all outputs 0, lock_o=0. After release, the next meas_vld needs two fresh crossings and reports period_o=32.
- Half-amplitude sine (range 64..192, period 16) -> period_o=16, vmax_o=192, vmin_o=64, amp_o=128.
